conv_seq_ctrl: RTL and testbench

//  Sequencer for conv_blk's DSP-cascade datapath: on i_go, walks every output position of one

---
 rtl/conv_seq_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_conv_seq_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_seq_ctrl.sv
// Convolution sequencer: walks every output position of a KxK convolution over an NxN map,
// issuing FM/weight tap addresses, draining the DSP cascade and handing off each result.
module conv_seq_ctrl #(
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned FM_SIZE     = 4,
  parameter int unsigned PADDING     = 0,
  parameter int unsigned STRIDE      = 1,
  parameter int unsigned PIPE_LAT    = 4,
  localparam int unsigned OUT_SIZE   = (FM_SIZE + 2 * PADDING - KERNEL_SIZE) / STRIDE + 1,
  localparam int unsigned FM_AW      = (FM_SIZE * FM_SIZE > 1) ? $clog2(FM_SIZE * FM_SIZE) : 1,
  localparam int unsigned WT_AW      = (KERNEL_SIZE * KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE * KERNEL_SIZE) : 1,
  localparam int unsigned OUT_AW     = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_go,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_fm_rd_en,
  output logic [FM_AW-1:0]  o_fm_addr,
  output logic [WT_AW-1:0]  o_wt_addr,
  output logic              o_pad_zero,
  output logic              o_tap_valid,
  output logic              o_acc_clr,
  input  logic [47:0]       i_acc,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic [47:0]       o_res_data,
  output logic [OUT_AW-1:0] o_res_row,
  output logic [OUT_AW-1:0] o_res_col
);

  localparam int unsigned KW = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam int unsigned DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [KW-1:0]     KLAST = KW'(KERNEL_SIZE - 1);
  localparam logic [DW-1:0]     DLAST = DW'(PIPE_LAT - 1);
  localparam logic [OUT_AW-1:0] OLAST = OUT_AW'(OUT_SIZE - 1);

  typedef enum logic [2:0] {S_IDLE, S_FEED, S_DRAIN, S_OUT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [OUT_AW-1:0]  orow_q, orow_d, ocol_q, ocol_d;
  logic [KW-1:0]      kr_q, kr_d, kc_q, kc_d;
  logic [DW-1:0]      dcnt_q, dcnt_d;
  logic [47:0]        res_data_q, res_data_d;
  logic [OUT_AW-1:0]  res_row_q, res_row_d, res_col_q, res_col_d;
  logic               busy_q, busy_d, done_q, done_d, rd_en_q, rd_en_d;
  logic               pad_q, pad_d, tap_q, tap_d, clr_q, clr_d, rvld_q, rvld_d;
  logic [FM_AW-1:0]   fm_addr_q, fm_addr_d;
  logic [WT_AW-1:0]   wt_addr_q, wt_addr_d;
  int                 ir_c, ic_c;

  // Next state, counters, and outputs registered from the next-state view so they align with the state
  always_comb begin
    state_d    = state_q;
    orow_d     = orow_q;
    ocol_d     = ocol_q;
    kr_d       = kr_q;
    kc_d       = kc_q;
    dcnt_d     = dcnt_q;
    res_data_d = res_data_q;
    res_row_d  = res_row_q;
    res_col_d  = res_col_q;
    case (state_q)
      S_IDLE: if (i_go) begin
        state_d = S_FEED;
        orow_d  = '0;
        ocol_d  = '0;
        kr_d    = '0;
        kc_d    = '0;
      end
      S_FEED: if (kc_q == KLAST) begin
        kc_d = '0;
        if (kr_q == KLAST) begin
          kr_d    = '0;
          dcnt_d  = '0;
          state_d = S_DRAIN;
        end else begin
          kr_d = kr_q + 1'b1;
        end
      end else begin
        kc_d = kc_q + 1'b1;
      end
      S_DRAIN: if (dcnt_q == DLAST) begin
        state_d    = S_OUT;
        res_data_d = i_acc;
        res_row_d  = orow_q;
        res_col_d  = ocol_q;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
      S_OUT: if (i_res_ready) begin
        if (ocol_q == OLAST) begin
          ocol_d = '0;
          orow_d = orow_q + 1'b1;
        end else begin
          ocol_d = ocol_q + 1'b1;
        end
        state_d = (ocol_q == OLAST && orow_q == OLAST) ? S_DONE : S_FEED;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Signed input coordinates of the tap about to be issued
    ir_c = int'(orow_d) * int'(STRIDE) + int'(kr_d) - int'(PADDING);
    ic_c = int'(ocol_d) * int'(STRIDE) + int'(kc_d) - int'(PADDING);

    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    rvld_d    = (state_d == S_OUT);
    tap_d     = (state_d == S_FEED);
    clr_d     = 1'b0;
    pad_d     = 1'b0;
    rd_en_d   = 1'b0;
    fm_addr_d = '0;
    wt_addr_d = '0;
    if (tap_d) begin
      clr_d     = (kr_d == '0) && (kc_d == '0);
      wt_addr_d = WT_AW'(int'(kr_d) * int'(KERNEL_SIZE) + int'(kc_d));
      if (ir_c < 0 || ic_c < 0 || ir_c >= int'(FM_SIZE) || ic_c >= int'(FM_SIZE)) begin
        pad_d = 1'b1;
      end else begin
        rd_en_d   = 1'b1;
        fm_addr_d = FM_AW'(ir_c * int'(FM_SIZE) + ic_c);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q    <= S_IDLE;
      orow_q     <= '0;
      ocol_q     <= '0;
      kr_q       <= '0;
      kc_q       <= '0;
      dcnt_q     <= '0;
      res_data_q <= '0;
      res_row_q  <= '0;
      res_col_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      pad_q      <= 1'b0;
      tap_q      <= 1'b0;
      clr_q      <= 1'b0;
      rvld_q     <= 1'b0;
      fm_addr_q  <= '0;
      wt_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      orow_q     <= orow_d;
      ocol_q     <= ocol_d;
      kr_q       <= kr_d;
      kc_q       <= kc_d;
      dcnt_q     <= dcnt_d;
      res_data_q <= res_data_d;
      res_row_q  <= res_row_d;
      res_col_q  <= res_col_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_en_q    <= rd_en_d;
      pad_q      <= pad_d;
      tap_q      <= tap_d;
      clr_q      <= clr_d;
      rvld_q     <= rvld_d;
      fm_addr_q  <= fm_addr_d;
      wt_addr_q  <= wt_addr_d;
    end
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_fm_rd_en  = rd_en_q;
  assign o_fm_addr   = fm_addr_q;
  assign o_wt_addr   = wt_addr_q;
  assign o_pad_zero  = pad_q;
  assign o_tap_valid = tap_q;
  assign o_acc_clr   = clr_q;
  assign o_res_valid = rvld_q;
  assign o_res_data  = res_data_q;
  assign o_res_row   = res_row_q;
  assign o_res_col   = res_col_q;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl: three parameterisations (default, padded, strided) checked against
// a tap/result scoreboard built from the addressing rules.
module tb_conv_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  go;
  logic        ready;
  logic [47:0] acc;

  always #5 clk = ~clk;

  logic [2:0]  busy, done, rd, pad, tv, clr, rv;
  logic [3:0]  fa0, fa1, wa0, wa1, wa2;
  logic [4:0]  fa2;
  logic [47:0] rdat0, rdat1, rdat2;
  logic [0:0]  row0, col0, row2, col2;
  logic [1:0]  row1, col1;

  conv_seq_ctrl u0 (
    .i_clk(clk), .i_rst(rst_n), .i_go(go[0]), .o_busy(busy[0]), .o_done(done[0]),
    .o_fm_rd_en(rd[0]), .o_fm_addr(fa0), .o_wt_addr(wa0), .o_pad_zero(pad[0]),
    .o_tap_valid(tv[0]), .o_acc_clr(clr[0]), .i_acc(acc), .o_res_valid(rv[0]),
    .i_res_ready(ready), .o_res_data(rdat0), .o_res_row(row0), .o_res_col(col0));

  conv_seq_ctrl #(.PADDING(1)) u1 (
    .i_clk(clk), .i_rst(rst_n), .i_go(go[1]), .o_busy(busy[1]), .o_done(done[1]),
    .o_fm_rd_en(rd[1]), .o_fm_addr(fa1), .o_wt_addr(wa1), .o_pad_zero(pad[1]),
    .o_tap_valid(tv[1]), .o_acc_clr(clr[1]), .i_acc(acc), .o_res_valid(rv[1]),
    .i_res_ready(ready), .o_res_data(rdat1), .o_res_row(row1), .o_res_col(col1));

  conv_seq_ctrl #(.FM_SIZE(5), .STRIDE(2)) u2 (
    .i_clk(clk), .i_rst(rst_n), .i_go(go[2]), .o_busy(busy[2]), .o_done(done[2]),
    .o_fm_rd_en(rd[2]), .o_fm_addr(fa2), .o_wt_addr(wa2), .o_pad_zero(pad[2]),
    .o_tap_valid(tv[2]), .o_acc_clr(clr[2]), .i_acc(acc), .o_res_valid(rv[2]),
    .i_res_ready(ready), .o_res_data(rdat2), .o_res_row(row2), .o_res_col(col2));

  typedef struct { int pad; int addr; int wt; int clr; } tap_t;
  typedef struct { logic [47:0] data; int row; int col; } res_t;

  int checks = 0;
  int errors = 0;
  int fa_first[9];
  int pad_first[9];
  int pos_addr[16];

  logic        s_busy, s_done, s_rd, s_pad, s_tv, s_clr, s_rv;
  int          s_fa, s_wa, s_row, s_col;
  logic [47:0] s_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample(input int d);
    s_busy = busy[d]; s_done = done[d]; s_rd = rd[d]; s_pad = pad[d];
    s_tv = tv[d]; s_clr = clr[d]; s_rv = rv[d];
    case (d)
      0: begin s_fa = int'(fa0); s_wa = int'(wa0); s_data = rdat0; s_row = int'(row0); s_col = int'(col0); end
      1: begin s_fa = int'(fa1); s_wa = int'(wa1); s_data = rdat1; s_row = int'(row1); s_col = int'(col1); end
      default: begin s_fa = int'(fa2); s_wa = int'(wa2); s_data = rdat2; s_row = int'(row2); s_col = int'(col2); end
    endcase
  endtask

  // One full job on instance d; abort_taps>0 pulses reset in the drain after that many taps
  task automatic run_job(input int d, input int n, input int p, input int s, input int stall_pos,
                         input int stall_len, input int abort_taps, input int noise_at);
    int osz, c, ntap, nclr, nhs, first_v, done_c, ndone, stall_rem, budget, ir, ic;
    bit fin;
    tap_t tq[$];
    res_t rq[$];
    tap_t t;
    res_t r;
    osz = (n + 2 * p - 3) / s + 1;
    for (int orow = 0; orow < osz; orow++)
      for (int ocol = 0; ocol < osz; ocol++)
        for (int kr = 0; kr < 3; kr++)
          for (int kc = 0; kc < 3; kc++) begin
            ir = orow * s + kr - p;
            ic = ocol * s + kc - p;
            t.pad  = (ir < 0 || ic < 0 || ir >= n || ic >= n) ? 1 : 0;
            t.addr = t.pad ? 0 : ir * n + ic;
            t.wt   = kr * 3 + kc;
            t.clr  = (kr == 0 && kc == 0) ? 1 : 0;
            tq.push_back(t);
          end
    ntap = 0; nclr = 0; nhs = 0; first_v = -1; done_c = -1; ndone = 0;
    stall_rem = stall_len; fin = 0;
    budget = osz * osz * 14 + stall_len + 20;
    ready = 1'b1;
    go[d] = 1'b1;
    @(posedge clk); #1;
    go[d] = 1'b0;
    c = 1;
    while (!fin) begin
      sample(d);
      chk("busy", s_busy, 1);
      if (s_tv) begin
        if (tq.size() == 0) chk("extra_tap", 1, 0);
        else begin
          t = tq.pop_front();
          chk("pad_zero", s_pad, t.pad);
          chk("fm_rd_en", s_rd, !t.pad);
          chk("fm_addr", s_fa, t.addr);
          chk("wt_addr", s_wa, t.wt);
          chk("acc_clr", s_clr, t.clr);
        end
        if (ntap < 9) begin fa_first[ntap] = s_fa; pad_first[ntap] = int'(s_pad); end
        ntap++;
        if (s_clr) begin
          if (nclr < 16) pos_addr[nclr] = s_fa;
          acc = (nclr == stall_pos) ? 48'hFFFF_FFFF_FFF0 : 48'({$urandom(), $urandom()});
          r.data = acc; r.row = nclr / osz; r.col = nclr % osz;
          rq.push_back(r);
          nclr++;
        end
      end else begin
        chk("tap_idle", {s_pad, s_rd, s_clr, 32'(s_fa), 32'(s_wa)}, 0);
      end
      if (abort_taps > 0 && ntap == abort_taps && !s_tv) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sample(d);
        chk("abort_outs", {s_busy, s_done, s_rd, s_pad, s_tv, s_clr, s_rv, 32'(s_fa), 32'(s_wa)}, 0);
        chk("abort_res", {s_data, 8'(s_row), 8'(s_col)}, 0);
        for (int i = 0; i < 20; i++) begin
          @(posedge clk); #1;
          sample(d);
          chk("abort_idle", {s_busy, s_done, s_tv}, 0);
        end
        return;
      end
      if (s_rv) begin
        if (first_v < 0) first_v = c;
        if (rq.size() == 0) chk("extra_res", 1, 0);
        else begin
          chk("res_data", s_data, rq[0].data);
          chk("res_row", s_row, rq[0].row);
          chk("res_col", s_col, rq[0].col);
          if (nhs == stall_pos && stall_rem > 0) begin
            ready = 1'b0;
            stall_rem--;
          end else begin
            ready = 1'b1;
            void'(rq.pop_front());
            nhs++;
          end
        end
      end else begin
        ready = 1'b1;
      end
      if (s_done) begin
        ndone++;
        done_c = c;
        fin = 1;
      end
      go[d] = (noise_at > 0 && c >= noise_at && c < noise_at + 3) ? 1'b1 : 1'b0;
      if (c > budget) begin
        chk("timeout", 0, 1);
        fin = 1;
      end
      @(posedge clk); #1;
      c++;
    end
    go[d] = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample(d);
      chk("post_idle", {s_busy, s_done, s_tv, s_rv}, 0);
      @(posedge clk); #1;
    end
    chk("first_valid_cycle", first_v, 14);
    chk("done_cycle", done_c, osz * osz * 14 + 1 + stall_len);
    chk("done_count", ndone, 1);
    chk("taps_left", tq.size(), 0);
    chk("results_left", rq.size(), 0);
    chk("results_seen", nhs, osz * osz);
  endtask

  initial begin
    int exp_addr[9];
    int exp_pad[9];
    exp_addr = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    exp_pad  = '{1, 1, 1, 1, 0, 0, 1, 0, 0};
    rst_n = 1'b0;
    go    = 3'b000;
    ready = 1'b1;
    acc   = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      sample(d);
      chk("reset_outs", {s_busy, s_done, s_rd, s_pad, s_tv, s_clr, s_rv, 32'(s_fa), 32'(s_wa)}, 0);
      chk("reset_res", {s_data, 8'(s_row), 8'(s_col)}, 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Default map, with go pulsed while busy
    run_job(0, 4, 0, 1, -1, 0, 0, 20);
    for (int i = 0; i < 9; i++) chk("dflt_addr_seq", fa_first[i], exp_addr[i]);

    // Result stall of 5 cycles on position 1, captured value -16
    run_job(0, 4, 0, 1, 1, 5, 0, 0);

    // Padding 1
    run_job(1, 4, 1, 1, -1, 0, 0, 0);
    for (int i = 0; i < 9; i++) chk("pad_pattern", pad_first[i], exp_pad[i]);
    chk("pad_addr4", fa_first[4], 0);
    chk("pad_addr5", fa_first[5], 1);
    chk("pad_addr7", fa_first[7], 4);
    chk("pad_addr8", fa_first[8], 5);

    // FM 5, stride 2
    run_job(2, 5, 0, 2, -1, 0, 0, 0);
    chk("stride_pos01", pos_addr[1], 2);
    chk("stride_pos10", pos_addr[2], 10);

    // Reset in the drain of position 2, then a fresh job
    run_job(0, 4, 0, 1, -1, 0, 27, 0);
    run_job(0, 4, 0, 1, -1, 0, 0, 0);
    chk("restart_addr0", fa_first[0], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
